// File: rtl/chunked_seq_adder.sv
// ---------------------------------------------------------------------------
// chunked_seq_adder
//   Multi-cycle adder/subtractor. Adds (or subtracts) two WIDTH-bit operands
//   CHUNK bits per clock, carrying between chunks in an internal register.
//   Operands are captured at acceptance. The result appears only at
//   completion, together with a one-cycle done pulse.
//
// Parameters
//   WIDTH  operand/result width, a positive multiple of CHUNK
//   CHUNK  bits processed per clock (1..WIDTH)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request, accepted on an edge where ready=1
//   ready      block is idle and can accept start
//   x, y       operands, sampled at acceptance
//   carry_in   carry in (add) / borrow in (sub), sampled at acceptance
//   sub        0: x+y+carry_in, 1: x-y-carry_in, sampled at acceptance
//   sum        result, held until the next completion
//   carry_out  carry out of the MSB (sub: 1 = no borrow)
//   overflow   two's-complement signed overflow of the completed op
//   done       one-cycle pulse marking a new result
// ---------------------------------------------------------------------------
module chunked_seq_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             carry_in,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             done
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]       state_p0;
  logic [KW-1:0]    k_p0;
  logic             c_p0;
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic [WIDTH-1:0] acc_p0;

  logic [31:0]      off;
  logic [CHUNK-1:0] a_ch;
  logic [CHUNK-1:0] b_ch;
  logic [CHUNK:0]   ch_sum;
  logic             msb_cin;
  logic [WIDTH-1:0] chunk_mask;
  logic [WIDTH-1:0] acc_nxt;
  logic             last;
  logic             accept;

  // ready is a direct decode of the state register, so it stays glitch-free.
  assign ready  = (state_p0 == IDLE);
  assign accept = ready && start;
  assign last   = (k_p0 == K_LAST);

  // Chunk k adder: select the chunk by shifting, add with the running carry.
  always_comb begin
    off        = 32'(k_p0) * 32'(CHUNK);
    a_ch       = CHUNK'(a_p0 >> off);
    b_ch       = CHUNK'(b_p0 >> off);
    ch_sum     = {1'b0, a_ch} + {1'b0, b_ch} + (CHUNK+1)'(c_p0);
    // Carry into this chunk's top bit, recovered from the sum bit; on the
    // last chunk this is the carry into the word MSB.
    msb_cin    = a_ch[CHUNK-1] ^ b_ch[CHUNK-1] ^ ch_sum[CHUNK-1];
    chunk_mask = {WIDTH{1'b1}} >> (WIDTH - CHUNK);
    acc_nxt    = (acc_p0 & ~(chunk_mask << off))
               | (WIDTH'(ch_sum[CHUNK-1:0]) << off);
  end

  // Operand and accumulator storage: pure data, no reset needed because
  // nothing reads it before an acceptance has loaded it.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0 <= x;
      b_p0 <= sub ? ~y : y;
    end
    if (state_p0 == BUSY) begin
      acc_p0 <= acc_nxt;
    end
  end

  // Control, carry and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0  <= IDLE;
      k_p0      <= '0;
      c_p0      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state_p0 == IDLE) begin
        if (start) begin
          c_p0     <= sub ? ~carry_in : carry_in;
          k_p0     <= '0;
          state_p0 <= BUSY;
        end
      end else begin
        c_p0 <= ch_sum[CHUNK];
        k_p0 <= k_p0 + KW'(1);
        if (last) begin
          sum       <= acc_nxt;
          carry_out <= ch_sum[CHUNK];
          overflow  <= msb_cin ^ ch_sum[CHUNK];
          done      <= 1'b1;
          k_p0      <= '0;
          state_p0  <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_chunked_seq_adder.sv
module tb_chunked_seq_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, carry_in, sub;
  logic [31:0] x, y, sum;
  logic        ready, carry_out, overflow, done;

  logic        start8, ci8, sub8;
  logic [7:0]  x8, y8, sum8;
  logic        ready8, cout8, ovf8, done8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  chunked_seq_adder #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready),
    .x(x), .y(y), .carry_in(carry_in), .sub(sub),
    .sum(sum), .carry_out(carry_out), .overflow(overflow), .done(done)
  );

  chunked_seq_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .ready(ready8),
    .x(x8), .y(y8), .carry_in(ci8), .sub(sub8),
    .sum(sum8), .carry_out(cout8), .overflow(ovf8), .done(done8)
  );

  // Drives one request on the wide instance and waits for done.
  // lat = number of edges after acceptance until done, -1 on timeout.
  task automatic run_op(input logic [31:0] xa, input logic [31:0] ya,
                        input logic ci, input logic sb, output int lat);
    x = xa; y = ya; carry_in = ci; sub = sb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; x = '0; y = '0; carry_in = 1'b0; sub = 1'b0;
    start8 = 1'b0; x8 = '0; y8 = '0; ci8 = 1'b0; sub8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (sum !== 32'h0) begin errors++; $display("FAIL reset_sum got=%h exp=0", sum); end
    checks++; if (carry_out !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b exp=00", carry_out, overflow); end
    checks++; if (ready8 !== 1'b1 || sum8 !== 8'h0) begin errors++; $display("FAIL reset_narrow got ready=%b sum=%h exp ready=1 sum=0", ready8, sum8); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add_wrap();
    int lat;
    x = 32'hFFFFFFFF; y = 32'h1; carry_in = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL busy_ready got=%b exp=0", ready); end
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      if (i < 4 && sum !== 32'h0) begin
        checks++; errors++; $display("FAIL partial_sum cycle=%0d got=%h exp=0", i, sum);
      end
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    checks++; if (lat !== 4) begin errors++; $display("FAIL wrap_latency got=%0d exp=4", lat); end
    checks++; if (sum !== 32'h0) begin errors++; $display("FAIL wrap_sum got=%h exp=00000000", sum); end
    checks++; if (carry_out !== 1'b1) begin errors++; $display("FAIL wrap_cout got=%b exp=1", carry_out); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL wrap_ovf got=%b exp=0", overflow); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL done_ready got=%b exp=1", ready); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_width got=%b exp=0", done); end
    checks++; if (sum !== 32'h0 || carry_out !== 1'b1) begin errors++; $display("FAIL hold_result got=%h/%b exp=00000000/1", sum, carry_out); end
  endtask

  task automatic test_signed_overflow();
    int lat;
    run_op(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL ovf_latency got=%0d exp=4", lat); end
    checks++; if (sum !== 32'h80000000) begin errors++; $display("FAIL ovf_sum got=%h exp=80000000", sum); end
    checks++; if (carry_out !== 1'b0 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_flags got cout=%b ovf=%b exp cout=0 ovf=1", carry_out, overflow); end
  endtask

  task automatic test_subtract();
    int lat;
    run_op(32'd5, 32'd7, 1'b0, 1'b1, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL sub_latency got=%0d exp=4", lat); end
    checks++; if (sum !== 32'hFFFFFFFE) begin errors++; $display("FAIL sub_sum got=%h exp=FFFFFFFE", sum); end
    checks++; if (carry_out !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL sub_flags got cout=%b ovf=%b exp cout=0 ovf=0", carry_out, overflow); end
    run_op(32'd5, 32'd7, 1'b1, 1'b1, lat);
    checks++; if (sum !== 32'hFFFFFFFD) begin errors++; $display("FAIL sub_borrow_sum got=%h exp=FFFFFFFD", sum); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL sub_borrow_cout got=%b exp=0", carry_out); end
    run_op(32'd9, 32'd4, 1'b0, 1'b1, lat);
    checks++; if (sum !== 32'd5 || carry_out !== 1'b1) begin errors++; $display("FAIL sub_noborrow got=%h/%b exp=00000005/1", sum, carry_out); end
  endtask

  task automatic test_back_to_back();
    int ndone;
    int lat;
    x = 32'h1; y = 32'h2; carry_in = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    @(posedge clk); #1;
    if (done) ndone++;
    // start during BUSY with new operands must be ignored
    start = 1'b1; x = 32'h100; y = 32'h200;
    for (int i = 2; i <= 4; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL busy_start_dones got=%0d exp=1", ndone); end
    checks++; if (sum !== 32'h3) begin errors++; $display("FAIL busy_start_sum got=%h exp=00000003", sum); end
    // start still high in the done cycle: accepted with fresh operands
    x = 32'h10; y = 32'h20;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    checks++; if (lat !== 4) begin errors++; $display("FAIL b2b_latency got=%0d exp=4", lat); end
    checks++; if (sum !== 32'h30) begin errors++; $display("FAIL b2b_sum got=%h exp=00000030", sum); end
  endtask

  task automatic test_reset_abort();
    int ndone;
    int lat;
    x = 32'hFFFFFFFF; y = 32'hFFFFFFFF; carry_in = 1'b1; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if (ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL abort_ctrl got ready=%b done=%b exp ready=1 done=0", ready, done); end
    checks++; if (sum !== 32'h0 || carry_out !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL abort_outputs got=%h/%b/%b exp=00000000/0/0", sum, carry_out, overflow); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", ndone); end
    run_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, lat);
    checks++; if (lat !== 4 || sum !== 32'h23456789) begin errors++; $display("FAIL post_abort_op got lat=%0d sum=%h exp lat=4 sum=23456789", lat, sum); end
  endtask

  task automatic test_single_chunk();
    int lat;
    x8 = 8'hC8; y8 = 8'h64; ci8 = 1'b1; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (done8) begin lat = i; break; end
    end
    checks++; if (lat !== 1) begin errors++; $display("FAIL n1_latency got=%0d exp=1", lat); end
    checks++; if (sum8 !== 8'h2D) begin errors++; $display("FAIL n1_sum got=%h exp=2D", sum8); end
    checks++; if (cout8 !== 1'b1 || ovf8 !== 1'b0) begin errors++; $display("FAIL n1_flags got cout=%b ovf=%b exp cout=1 ovf=0", cout8, ovf8); end
    // 0x7F + 0x01 with a narrow word: signed overflow from a single chunk
    x8 = 8'h7F; y8 = 8'h01; ci8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(posedge clk); #1;
    checks++; if (done8 !== 1'b1 || sum8 !== 8'h80 || ovf8 !== 1'b1 || cout8 !== 1'b0) begin
      errors++; $display("FAIL n1_ovf got done=%b sum=%h ovf=%b cout=%b exp 1/80/1/0", done8, sum8, ovf8, cout8);
    end
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_signed_overflow();
    test_subtract();
    test_back_to_back();
    test_reset_abort();
    test_single_chunk();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
